// File: rtl/led_matrix_pkg.sv
// Shared types for the 8x8 LED matrix scan driver.
//   ROWS/COLS  : matrix geometry
//   row_idx_t  : binary row select (decoded off-chip)
//   col_bits_t : one row's column pattern
//   frame_t    : packed whole-frame buffer, for use by the top level
package led_matrix_pkg;

  localparam int unsigned ROWS = 8;
  localparam int unsigned COLS = 8;

  typedef logic [2:0]      row_idx_t;
  typedef logic [COLS-1:0] col_bits_t;
  typedef col_bits_t [0:ROWS-1] frame_t;

endpackage

// File: rtl/dynamic_matrix_led_if.sv
// Frame-buffer / pin bundle between the frame owner and the scan driver.
//   LEDdata : frame buffer, LEDdata[r] is the column pattern for row r
//   row     : currently selected row
//   col     : column drive for the selected row
// master = frame owner / board side, slave = scan driver.
interface dynamic_matrix_led_if;
  import led_matrix_pkg::*;

  col_bits_t LEDdata [0:ROWS-1];
  row_idx_t  row;
  col_bits_t col;

  modport master (output LEDdata, input row, input col);
  modport slave  (input LEDdata, output row, output col);

endinterface

// File: rtl/scan_timer.sv
// Row dwell timer: counts 0..DWELL-1 and flags the last cycle of each slot.
//   sys_clock, sys_reset : clock, synchronous active-high reset
//   cnt                  : position within the current row slot
//   slot_end             : high while cnt == DWELL-1 (registered)
module scan_timer #(
  parameter int unsigned DWELL = 27000,
  parameter int unsigned CNT_W = $clog2(DWELL)
) (
  input  logic             sys_clock,
  input  logic             sys_reset,
  output logic [CNT_W-1:0] cnt,
  output logic             slot_end
);

  // slot_end is precomputed one cycle ahead so it lines up with cnt == DWELL-1.
  always_ff @(posedge sys_clock) begin
    if (sys_reset) begin
      cnt      <= '0;
      slot_end <= 1'b0;
    end else if (slot_end) begin
      cnt      <= '0;
      slot_end <= 1'b0;
    end else begin
      cnt      <= cnt + CNT_W'(1);
      slot_end <= (cnt == CNT_W'(DWELL - 2));
    end
  end

endmodule

// File: rtl/dynamic_matrix_led.sv
// Scan driver for an 8x8 multiplexed LED matrix.
// One row is held for DWELL cycles; the first BLANK cycles of every slot
// drive COL_OFF to suppress ghosting, the rest drive LEDdata[row].
//   sys_clock, sys_reset : clock, synchronous active-high reset
//   bus (slave)          : LEDdata in, row/col out (both registered)
module dynamic_matrix_led
  import led_matrix_pkg::*;
#(
  parameter int unsigned DWELL   = 27000,
  parameter int unsigned BLANK   = 64,
  parameter col_bits_t   COL_OFF = 8'hFF
) (
  input  logic               sys_clock,
  input  logic               sys_reset,
  dynamic_matrix_led_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DWELL);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             slot_end;
  row_idx_t         row_q;
  row_idx_t         row_nxt;
  col_bits_t        col_q;

  scan_timer #(.DWELL(DWELL), .CNT_W(CNT_W)) u_scan_timer (
    .sys_clock (sys_clock),
    .sys_reset (sys_reset),
    .cnt       (cnt),
    .slot_end  (slot_end)
  );

  // Mirror the timer's next state so col is decided from the values that
  // become current on this edge; row and col therefore always switch together.
  always_comb begin
    row_nxt = row_q;
    cnt_nxt = cnt + CNT_W'(1);
    if (slot_end) begin
      row_nxt = row_q + 3'd1;
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge sys_clock) begin
    if (sys_reset) begin
      row_q <= '0;
      col_q <= (BLANK > 0) ? COL_OFF : bus.LEDdata[0];
    end else begin
      row_q <= row_nxt;
      col_q <= (32'(cnt_nxt) < BLANK) ? COL_OFF : bus.LEDdata[row_nxt];
    end
  end

  assign bus.row = row_q;
  assign bus.col = col_q;

endmodule

// File: tb/tb_dynamic_matrix_led.sv
// Bench for dynamic_matrix_led: one instance with DWELL=8/BLANK=2 and one
// with DWELL=8/BLANK=0 share clock, reset and frame data. The stimulus
// process pushes the expected row/col per edge; the monitor pops and checks.
module tb_dynamic_matrix_led;
  import led_matrix_pkg::*;

  typedef struct {
    int        cyc;
    row_idx_t  row;
    col_bits_t col_a;
    col_bits_t col_b;
  } exp_t;

  logic      sys_clock = 1'b0;
  logic      sys_reset = 1'b1;
  exp_t      exp_q[$];
  int        n_checks = 0;
  int        n_fail   = 0;
  int        cyc_no   = 0;
  col_bits_t data [0:7];
  int        m_cnt    = 0;
  row_idx_t  m_row    = '0;

  dynamic_matrix_led_if bus_a ();
  dynamic_matrix_led_if bus_b ();

  dynamic_matrix_led #(.DWELL(8), .BLANK(2), .COL_OFF(8'hFF)) dut_a (
    .sys_clock (sys_clock),
    .sys_reset (sys_reset),
    .bus       (bus_a.slave)
  );

  dynamic_matrix_led #(.DWELL(8), .BLANK(0), .COL_OFF(8'hFF)) dut_b (
    .sys_clock (sys_clock),
    .sys_reset (sys_reset),
    .bus       (bus_b.slave)
  );

  always #5 sys_clock = ~sys_clock;

  // Drive one clock's worth of inputs and queue what the next edge must produce.
  task automatic step(input logic rst);
    exp_t e;
    @(negedge sys_clock);
    sys_reset     = rst;
    bus_a.LEDdata = data;
    bus_b.LEDdata = data;
    if (rst) begin
      m_cnt = 0;
      m_row = '0;
    end else if (m_cnt == 7) begin
      m_cnt = 0;
      m_row = m_row + 3'd1;
    end else begin
      m_cnt = m_cnt + 1;
    end
    e.cyc   = cyc_no;
    e.row   = m_row;
    e.col_a = (m_cnt < 2) ? 8'hFF : data[m_row];
    e.col_b = data[m_row];
    cyc_no  = cyc_no + 1;
    exp_q.push_back(e);
  endtask

  // Free-run until the model sits at the given slot position (bounded).
  task automatic run_to(input int r, input int c);
    for (int i = 0; i < 80; i++) begin
      if (m_row == row_idx_t'(r) && m_cnt == c) return;
      step(1'b0);
    end
    n_checks = n_checks + 1;
    n_fail   = n_fail + 1;
    $display("FAIL run_to: model never reached row %0d cnt %0d", r, c);
  endtask

  task automatic chk(input string name, input int cyc, input logic [7:0] act, input logic [7:0] req);
    n_checks = n_checks + 1;
    if (act !== req) begin
      n_fail = n_fail + 1;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  // Monitor: outputs are valid every cycle, so one entry is consumed per edge.
  always @(posedge sys_clock) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("row_a", e.cyc, 8'(bus_a.row), 8'(e.row));
      chk("row_b", e.cyc, 8'(bus_b.row), 8'(e.row));
      chk("col_a", e.cyc, bus_a.col, e.col_a);
      chk("col_b", e.cyc, bus_b.col, e.col_b);
    end
  end

  initial begin
    for (int r = 0; r < 8; r++) begin
      data[r] = col_bits_t'(~(8'h80 >> r));
    end
    // Reset, then a full frame plus wrap: 7F, BF, ... FE per row.
    step(1'b1);
    step(1'b1);
    repeat (70) step(1'b0);

    // Data change mid-slot in the data window shows up one cycle later.
    run_to(0, 3);
    data[0] = 8'h00;
    repeat (4) step(1'b0);
    data[0] = 8'h7F;

    // Data change landing in the blank window stays hidden until cnt 2.
    run_to(7, 7);
    data[0] = 8'h00;
    repeat (4) step(1'b0);
    data[0] = 8'h7F;

    // All-off data on one row: the BLANK=0 instance must show FF only there.
    data[3] = 8'hFF;
    data[4] = 8'h5A;
    run_to(5, 6);

    // Mid-slot reset, then a full slot and the next row change.
    step(1'b1);
    repeat (20) step(1'b0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge sys_clock);
    if (exp_q.size() > 0) begin
      n_checks = n_checks + 1;
      n_fail   = n_fail + 1;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    @(negedge sys_clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
